// File: rtl/crossbar_4x4_route_ctrl.sv
// -----------------------------------------------------------------------------
// crossbar_4x4_route_ctrl
//
// Route-search controller for a 4x4 crossbar built from five 2x2 switches
// (A, B, C, D, E). A request gives the destination output of each of the four
// inputs. The block steps through the 5-bit control space one word per cycle,
// starting at zero, and returns the first (and therefore smallest) control word
// whose switch settings realise the request. If no word matches, it reports an
// error. The registered control output drives the crossbar directly, and it
// keeps its value after the result is consumed so the crossbar stays configured.
//
// Switch topology (1 = swap, 0 = pass):
//   A = ctrl[0] : (in1, in2)
//   B = ctrl[3] : (in3, in4)
//   C = ctrl[2] : (A.out2, B.out1)
//   D = ctrl[1] : (A.out1, C.out1) -> (out1, out2)
//   E = ctrl[4] : (C.out2, B.out2) -> (out3, out4)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    request present
//   req_ready    block can accept a request (high only in IDLE)
//   req_dst1..4  destination output of in1..in4 (0 = out1 .. 3 = out4)
//   cfg_valid    result available
//   cfg_ready    consumer accepts the result (only looked at in DONE)
//   cfg_control  control word for the crossbar
//   cfg_err      request is not routable; qualified by cfg_valid
//
// States:
//   state  | meaning
//   IDLE   | waiting for a request; req_ready high
//   SEARCH | testing one candidate control word per cycle
//   DONE   | result presented on cfg_*; waiting for cfg_ready
// -----------------------------------------------------------------------------
module crossbar_4x4_route_ctrl #(
    parameter int CAND_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_dst1,
    input  logic [1:0]        req_dst2,
    input  logic [1:0]        req_dst3,
    input  logic [1:0]        req_dst4,
    output logic              cfg_valid,
    input  logic              cfg_ready,
    output logic [CAND_W-1:0] cfg_control,
    output logic              cfg_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [CAND_W-1:0] CAND_LAST = '1;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [CAND_W-1:0] cand_q, cand_d;
    logic [1:0]        dst_q [4];
    logic [1:0]        dst_d [4];
    logic              cfg_valid_q, cfg_valid_d;
    logic              cfg_err_q, cfg_err_d;
    logic [CAND_W-1:0] cfg_control_q, cfg_control_d;

    // -------------------------------------------------------------------------
    // Switch network evaluation for the current candidate.
    // Each wire carries the index (0..3) of the input that reaches it, so the
    // four network outputs end up holding "which input lands here".
    // -------------------------------------------------------------------------
    logic [1:0] a_out1, a_out2;
    logic [1:0] b_out1, b_out2;
    logic [1:0] c_out1, c_out2;
    logic [1:0] out_src [4];
    logic       match;

    always_comb begin
        a_out1 = cand_q[0] ? 2'd1 : 2'd0;
        a_out2 = cand_q[0] ? 2'd0 : 2'd1;

        b_out1 = cand_q[3] ? 2'd3 : 2'd2;
        b_out2 = cand_q[3] ? 2'd2 : 2'd3;

        c_out1 = cand_q[2] ? b_out1 : a_out2;
        c_out2 = cand_q[2] ? a_out2 : b_out1;

        out_src[0] = cand_q[1] ? c_out1 : a_out1;
        out_src[1] = cand_q[1] ? a_out1 : c_out1;

        out_src[2] = cand_q[4] ? b_out2 : c_out2;
        out_src[3] = cand_q[4] ? c_out2 : b_out2;
    end

    // The network always produces a permutation, so checking that the input
    // reaching each output wanted that output covers all four inputs.
    always_comb begin
        match = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (dst_q[out_src[j]] != 2'(j)) begin
                match = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        dst_d         = dst_q;
        cfg_valid_d   = cfg_valid_q;
        cfg_err_d     = cfg_err_q;
        cfg_control_d = cfg_control_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    dst_d[0] = req_dst1;
                    dst_d[1] = req_dst2;
                    dst_d[2] = req_dst3;
                    dst_d[3] = req_dst4;
                    cand_d   = '0;
                    state_d  = ST_SEARCH;
                end
            end

            ST_SEARCH: begin
                if (match) begin
                    cfg_control_d = cand_q;
                    cfg_err_d     = 1'b0;
                    cfg_valid_d   = 1'b1;
                    state_d       = ST_DONE;
                end else if (cand_q != CAND_LAST) begin
                    cand_d = cand_q + 1'b1;
                end else begin
                    // Search space exhausted; never wrap back to zero.
                    cfg_control_d = '0;
                    cfg_err_d     = 1'b1;
                    cfg_valid_d   = 1'b1;
                    state_d       = ST_DONE;
                end
            end

            ST_DONE: begin
                // cfg_control is deliberately left alone so the crossbar keeps
                // its configuration after the handshake.
                if (cfg_ready) begin
                    cfg_valid_d = 1'b0;
                    cfg_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cfg_valid_d = 1'b0;
                cfg_err_d   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cand_q        <= '0;
            cfg_valid_q   <= 1'b0;
            cfg_err_q     <= 1'b0;
            cfg_control_q <= '0;
            for (int i = 0; i < 4; i++) begin
                dst_q[i] <= 2'd0;
            end
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            cfg_valid_q   <= cfg_valid_d;
            cfg_err_q     <= cfg_err_d;
            cfg_control_q <= cfg_control_d;
            for (int i = 0; i < 4; i++) begin
                dst_q[i] <= dst_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready   = (state_q == ST_IDLE);
    assign cfg_valid   = cfg_valid_q;
    assign cfg_err     = cfg_err_q;
    assign cfg_control = cfg_control_q;

endmodule

// File: tb/tb_crossbar_4x4_route_ctrl.sv
module tb_crossbar_4x4_route_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_dst1, req_dst2, req_dst3, req_dst4;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [4:0] cfg_control;
    logic       cfg_err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    crossbar_4x4_route_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dst1    (req_dst1),
        .req_dst2    (req_dst2),
        .req_dst3    (req_dst3),
        .req_dst4    (req_dst4),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_control (cfg_control),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Reference model: crossbar as a sequence of in-place slot swaps.
    // Slot j holds the input index currently on that wire.
    // ---------------------------------------------------------------------
    function automatic bit realises(input logic [4:0] c,
                                    input logic [1:0] d1, input logic [1:0] d2,
                                    input logic [1:0] d3, input logic [1:0] d4);
        int w[4];
        int d[4];
        int t;
        d[0] = int'(d1); d[1] = int'(d2); d[2] = int'(d3); d[3] = int'(d4);
        for (int i = 0; i < 4; i++) w[i] = i;
        if (c[0]) begin t = w[0]; w[0] = w[1]; w[1] = t; end   // A
        if (c[3]) begin t = w[2]; w[2] = w[3]; w[3] = t; end   // B
        if (c[2]) begin t = w[1]; w[1] = w[2]; w[2] = t; end   // C
        if (c[1]) begin t = w[0]; w[0] = w[1]; w[1] = t; end   // D
        if (c[4]) begin t = w[2]; w[2] = w[3]; w[3] = t; end   // E
        for (int j = 0; j < 4; j++)
            if (d[w[j]] != j) return 1'b0;
        return 1'b1;
    endfunction

    // Smallest realising control word, or -1 when none exists.
    function automatic int search(input logic [1:0] d1, input logic [1:0] d2,
                                  input logic [1:0] d3, input logic [1:0] d4);
        for (int c = 0; c < 32; c++)
            if (realises(5'(c), d1, d2, d3, d4)) return c;
        return -1;
    endfunction

    function automatic int latency_of(input int r);
        return (r < 0) ? 32 : r + 1;
    endfunction

    // Cycle-level expectation: after accept, result appears a fixed number of
    // edges later; the consumer handshake returns to idle.
    int         m_phase;   // 0 idle, 1 searching, 2 result held
    int         m_wait;
    int         m_res;
    logic       m_valid, m_err;
    logic [4:0] m_ctrl;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_wait  <= 0;
            m_res   <= 0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            m_ctrl  <= 5'd0;
        end else begin
            case (m_phase)
                0: if (req_valid) begin
                    m_res   <= search(req_dst1, req_dst2, req_dst3, req_dst4);
                    m_wait  <= latency_of(search(req_dst1, req_dst2, req_dst3, req_dst4));
                    m_phase <= 1;
                end
                1: if (m_wait == 1) begin
                    m_valid <= 1'b1;
                    m_err   <= (m_res < 0);
                    m_ctrl  <= (m_res < 0) ? 5'd0 : m_res[4:0];
                    m_phase <= 2;
                end else begin
                    m_wait <= m_wait - 1;
                end
                default: if (cfg_ready) begin
                    m_valid <= 1'b0;
                    m_err   <= 1'b0;
                    m_phase <= 0;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_req_ready", 32'(req_ready), 32'(m_phase == 0));
            check("cyc_cfg_valid", 32'(cfg_valid), 32'(m_valid));
            check("cyc_cfg_control", 32'(cfg_control), 32'(m_ctrl));
            check("cyc_cfg_err", 32'(cfg_err), 32'(m_err));
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (called at a negedge, return at a negedge)
    // ---------------------------------------------------------------------
    task automatic run_req(input logic [1:0] d1, input logic [1:0] d2,
                           input logic [1:0] d3, input logic [1:0] d4,
                           input int exp_ctrl, input int exp_err, input int exp_lat,
                           input string tag);
        int edges;
        check({tag, "_ready_before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_dst1 = d1; req_dst2 = d2; req_dst3 = d3; req_dst4 = d4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        // Scramble the fields: they must have been captured at accept.
        req_dst1 = ~d1; req_dst2 = d1; req_dst3 = ~d4; req_dst4 = d2;
        edges = 0;
        while (!cfg_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
        check({tag, "_control"}, 32'(cfg_control), 32'(exp_ctrl));
        check({tag, "_err"}, 32'(cfg_err), 32'(exp_err));
    endtask

    task automatic handshake(input int exp_ctrl, input string tag);
        cfg_ready = 1'b1;
        @(negedge clk);
        cfg_ready = 1'b0;
        check({tag, "_hs_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_hs_valid"}, 32'(cfg_valid), 32'd0);
        check({tag, "_hs_err"}, 32'(cfg_err), 32'd0);
        check({tag, "_hs_control"}, 32'(cfg_control), 32'(exp_ctrl));
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        cfg_ready = 1'b0;
        req_dst1 = 2'd0; req_dst2 = 2'd0; req_dst3 = 2'd0; req_dst4 = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_valid", 32'(cfg_valid), 32'd0);
        check("reset_err", 32'(cfg_err), 32'd0);
        check("reset_control", 32'(cfg_control), 32'd0);

        // Model pins: hand-derived answers.
        check("model_identity", 32'(search(2'd0, 2'd1, 2'd2, 2'd3)), 32'd0);
        check("model_swap12", 32'(search(2'd1, 2'd0, 2'd2, 2'd3)), 32'd1);
        check("model_c_only", 32'(search(2'd0, 2'd2, 2'd1, 2'd3)), 32'd4);
        check("model_reverse", 32'(search(2'd3, 2'd2, 2'd1, 2'd0)), 32'hFFFF_FFFF);

        run_req(2'd0, 2'd1, 2'd2, 2'd3, 0, 0, 1, "identity");
        handshake(0, "identity");

        run_req(2'd1, 2'd0, 2'd2, 2'd3, 1, 0, 2, "swap12");
        handshake(1, "swap12");

        run_req(2'd0, 2'd2, 2'd1, 2'd3, 4, 0, 5, "c_only");
        check("c_only_routes", 32'(realises(cfg_control, 2'd0, 2'd2, 2'd1, 2'd3)), 32'd1);

        // Hold in DONE with a competing request present.
        req_valid = 1'b1;
        req_dst1 = 2'd3; req_dst2 = 2'd2; req_dst3 = 2'd1; req_dst4 = 2'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(cfg_valid), 32'd1);
            check("hold_control", 32'(cfg_control), 32'd4);
            check("hold_err", 32'(cfg_err), 32'd0);
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        handshake(4, "hold");

        // Reset while searching at candidate 3.
        req_valid = 1'b1;
        req_dst1 = 2'd3; req_dst2 = 2'd2; req_dst3 = 2'd1; req_dst4 = 2'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_valid", 32'(cfg_valid), 32'd0);
        check("mid_rst_err", 32'(cfg_err), 32'd0);
        check("mid_rst_control", 32'(cfg_control), 32'd0);

        run_req(2'd0, 2'd1, 2'd2, 2'd3, 0, 0, 1, "post_rst");
        handshake(0, "post_rst");

        run_req(2'd3, 2'd2, 2'd1, 2'd0, 0, 1, 32, "reverse");
        handshake(0, "reverse");

        run_req(2'd0, 2'd0, 2'd1, 2'd2, 0, 1, 32, "duplicate");
        handshake(0, "duplicate");

        // All 24 permutations.
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 4; c++)
                    for (int d = 0; d < 4; d++) begin
                        if (a != b && a != c && a != d && b != c && b != d && c != d) begin
                            int r;
                            int rc;
                            r = search(2'(a), 2'(b), 2'(c), 2'(d));
                            rc = (r < 0) ? 0 : r;
                            run_req(2'(a), 2'(b), 2'(c), 2'(d), rc, (r < 0) ? 1 : 0,
                                    latency_of(r), "perm");
                            if (cfg_err)
                                check("perm_err_structural",
                                      32'(((a >= 2) && (b >= 2)) || ((c < 2) && (d < 2))), 32'd1);
                            else
                                check("perm_routes",
                                      32'(realises(cfg_control, 2'(a), 2'(b), 2'(c), 2'(d))), 32'd1);
                            handshake(rc, "perm");
                        end
                    end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crossbar_4x4_route_ctrl.md
Name: crossbar_4x4_route_ctrl

Overview:
Upstream configuration stage for the 4x4 4-bit crossbar, which is built from five 2x2 switches. It accepts a routing request giving the destination output of each of the four inputs. It searches the crossbar's 5-bit control space sequentially and returns the smallest control word that realises the request, or flags the request as unroutable. Its registered control output drives the crossbar's control input directly.

Parameters:
CAND_W, 5, candidate counter width; fixed to the crossbar control width, not to be overridden

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_dst1  input  2  destination of in1 (0=out1 .. 3=out4)
req_dst2  input  2  destination of in2
req_dst3  input  2  destination of in3
req_dst4  input  2  destination of in4
cfg_valid  output  1  result available
cfg_ready  input  1  consumer accepts result
cfg_control  output  5  control word for the crossbar
cfg_err  output  1  request not routable; qualified by cfg_valid

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. rst=1 at a rising edge forces the reset values below, overrides everything else, and aborts any search in progress.
- Reset values: state=IDLE, req_ready=1, cfg_valid=0, cfg_err=0, cfg_control=5'b00000, candidate=0.
- Switch model, 1 = swap, 0 = pass (out1=in1, out2=in2):
  - A = control[0]: inputs (in1, in2).
  - B = control[3]: inputs (in3, in4).
  - C = control[2]: inputs (A.out2, B.out1).
  - D = control[1]: inputs (A.out1, C.out1), drives (out1, out2).
  - E = control[4]: inputs (C.out2, B.out2), drives (out3, out4).
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch the four destinations, set candidate=0, go to SEARCH.
- SEARCH:
  - req_ready=0.
  - Each cycle, evaluate the switch model combinationally for the current candidate. Match means every input i lands on output req_dst_i.
  - On match: cfg_control<=candidate, cfg_err<=0, cfg_valid<=1, go to DONE.
  - No match and candidate<31: candidate increments by 1.
  - No match at candidate=31: cfg_control<=0, cfg_err<=1, cfg_valid<=1, go to DONE. No wrap-around.
- DONE:
  - req_ready=0. cfg_valid, cfg_control and cfg_err are held stable.
  - On cfg_valid&cfg_ready: cfg_valid<=0, go to IDLE. cfg_control keeps its value so the crossbar stays configured; cfg_err clears.
- Result selection: the search is ascending, so the smallest matching control word is always the one returned.
- Latency, with the accepting edge as edge 0:
  - A match at candidate k raises cfg_valid after edge k+1.
  - An error raises cfg_valid after edge 32.
- Throughput: at most one request in flight. At least one idle cycle between cfg handshake and the next accept.
- Invalid input: duplicate destinations are not specially detected; they exhaust the search and return cfg_err=1.
- Request fields are sampled only at accept; later changes to req_dst* have no effect.
- cfg_ready is ignored outside DONE.
- Structural limit: A.out1 always reaches out1/out2, and B.out2 always reaches out3/out4. Permutations sending both in1 and in2 to {out3, out4}, or both in3 and in4 to {out1, out2}, are unroutable and must return err.

Test Plan:
- Reset, then identity dst=(0,1,2,3) -> cfg_control=5'b00000, cfg_err=0, cfg_valid after edge 1; req_ready=0 until cfg handshake.
- dst=(1,0,2,3), swap in1/in2 -> cfg_control=5'b00001, cfg_err=0, cfg_valid after edge 2.
- dst=(0,2,1,3) -> cfg_control=5'b00100 (C swaps only), cfg_valid after edge 5. Feeding the crossbar gives out1=in1, out2=in3, out3=in2, out4=in4.
- Full reversal dst=(3,2,1,0), and duplicate dst=(0,0,1,2) -> cfg_err=1, cfg_control=0, cfg_valid after edge 32. Candidate never wraps.
- Hold cfg_ready=0 for 10 cycles in DONE -> outputs stable, new req_valid ignored. Then pulse cfg_ready -> IDLE next edge; cfg_control retained, cfg_err cleared, next request accepted.
- Assert rst during SEARCH at candidate 3 -> next edge all outputs at reset values, req_ready=1. A fresh identity request then completes normally.
- Exhaustive: all 24 permutations. Every returned cfg_control, applied to a crossbar model, realises the request. Every cfg_err case violates the structural limit.
